// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812B strip driver blocks: the frame
// sequencer state encoding, the pixel word width, the system clock rate
// and the default latch (strip reset) period derived from it.
// ---------------------------------------------------------------------------
package ws2812_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
      WAIT_TX,
      LATCH
   } state_t;

   localparam int PIXEL_W = 24;
   localparam int CLK_HZ  = 100_000_000;

   // 60 us of idle line, comfortably above the 50 us WS2812B reset time
   localparam int DEFAULT_LATCH_CYCLES = (CLK_HZ / 1_000_000) * 60;

endpackage

// File: rtl/ws2812_frame_sequencer_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Load/count/expire down-counter. A load pulse arms the timer; expire is
// high for exactly one cycle, COUNT cycles after the load edge. Shared
// between the frame latch wait and the bit serializer.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-low reset
//   load    in   arm the timer (restarts it if already running)
//   expire  out  one-cycle pulse on the final counted cycle
// ---------------------------------------------------------------------------
module cycle_timer #(
   parameter int COUNT = 6000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire
);

   localparam int CNT_W = $clog2(COUNT + 1);

   logic [CNT_W-1:0] count;
   logic             running;

   // Loading COUNT-1 makes the zero-count cycle the COUNT-th cycle after
   // the load edge, so the owner acts on expire at exactly load + COUNT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count   <= '0;
         running <= 1'b0;
      end else if (load) begin
         count   <= CNT_W'(COUNT - 1);
         running <= 1'b1;
      end else if (running) begin
         if (count == '0)
            running <= 1'b0;
         else
            count <= count - CNT_W'(1);
      end
   end

   assign expire = running && (count == '0);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ---------------------------------------------------------------------------
// ws2812_frame_sequencer
// Frame-level controller for a WS2812B strip. Each accepted frame tick
// fetches NUM_LEDS pixels from the pixel source, hands each GRB word to
// the bit serializer, then holds the line idle for LATCH_CYCLES clocks.
// Counts completed frames and flags ticks that arrive mid-frame.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   synchronous, active-low reset
//   enable      in   permits new frames to start
//   tick        in   one-cycle frame-start strobe
//   pix_req     out  pixel request, held until pix_valid
//   pix_idx     out  index of the requested pixel
//   pix_valid   in   pix_data is valid for pix_idx
//   pix_data    in   24-bit GRB pixel word
//   tx_start    out  one-cycle start pulse to the serializer
//   tx_data     out  registered pixel word for the serializer
//   tx_busy     in   serializer busy (rises the cycle after tx_start)
//   busy        out  sequencer is inside a frame
//   frame_done  out  one-cycle pulse at the end of the latch period
//   overrun     out  sticky, a tick was lost mid-frame
//   frame_cnt   out  completed frame count (wraps)
// ---------------------------------------------------------------------------
module ws2812_frame_sequencer
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int IDX_W        = 8,
   parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               tick,
   output logic               pix_req,
   output logic [IDX_W-1:0]   pix_idx,
   input  logic               pix_valid,
   input  logic [PIXEL_W-1:0] pix_data,
   output logic               tx_start,
   output logic [PIXEL_W-1:0] tx_data,
   input  logic               tx_busy,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun,
   output logic [15:0]        frame_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

   state_t state;
   logic   wait_first;
   logic   latch_load;
   logic   latch_expire;

   // The latch timer is armed on the same edge that moves WAIT_TX into
   // LATCH, so its expire lands on the last LATCH cycle.
   assign latch_load = (state == WAIT_TX) && !wait_first && !tx_busy &&
                       (pix_idx == LAST_IDX);

   cycle_timer #(
      .COUNT (LATCH_CYCLES)
   ) u_latch_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (latch_load),
      .expire (latch_expire)
   );

   // Frame sequencer. pix_idx doubles as the pixel counter. wait_first
   // marks the first WAIT_TX cycle, where tx_busy has not risen yet.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         wait_first <= 1'b0;
         pix_req    <= 1'b0;
         pix_idx    <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         tx_start   <= 1'b0;
         frame_done <= 1'b0;

         // Any tick outside IDLE is dropped, including the final LATCH cycle
         if (tick && (state != IDLE))
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick && enable) begin
                  state   <= FETCH;
                  pix_idx <= '0;
                  pix_req <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            FETCH: begin
               if (pix_valid) begin
                  tx_data <= pix_data;
                  pix_req <= 1'b0;
                  state   <= SEND;
               end
            end

            SEND: begin
               if (!tx_busy) begin
                  tx_start   <= 1'b1;
                  wait_first <= 1'b1;
                  state      <= WAIT_TX;
               end
            end

            WAIT_TX: begin
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (!tx_busy) begin
                  if (pix_idx == LAST_IDX) begin
                     state <= LATCH;
                  end else begin
                     pix_idx <= pix_idx + IDX_W'(1);
                     pix_req <= 1'b1;
                     state   <= FETCH;
                  end
               end
            end

            LATCH: begin
               if (latch_expire) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_frame_sequencer
// Self-checking bench for ws2812_frame_sequencer (NUM_LEDS=4,
// LATCH_CYCLES=20). A pixel source and a serializer with configurable
// latencies drive the DUT; a frame-level reference model tracks whether a
// frame is in flight, which pixel is due next, when the frame must end,
// the frame count and the sticky overrun flag.
// ---------------------------------------------------------------------------
module tb_ws2812_frame_sequencer;

   localparam int NUM_LEDS = 4;
   localparam int IDX_W    = 8;
   localparam int LATCH    = 20;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             tick;
   logic             pix_req;
   logic [IDX_W-1:0] pix_idx;
   logic             pix_valid;
   logic [23:0]      pix_data;
   logic             tx_start;
   logic [23:0]      tx_data;
   logic             tx_busy;
   logic             busy;
   logic             frame_done;
   logic             overrun;
   logic [15:0]      frame_cnt;

   int total = 0;
   int bad   = 0;

   // Stimulus-owned settings, read by the models
   int          src_delay = 0;
   int          busy_len  = 1;
   logic [23:0] mem [NUM_LEDS];
   bit          preload_flag = 1'b0;

   // Model-owned state
   int          cyc = 0;
   bit          s_tick, s_en, s_rst;
   bit          in_frame = 1'b0;
   bit          exp_ovr = 1'b0;
   bit          end_known = 1'b0;
   bit          done_now, started;
   bit          preload_done = 1'b0;
   int          exp_end = 0;
   int          exp_pix = 0;
   int          falls = 0;
   logic [15:0] exp_frames = '0;
   bit          ser_pending = 1'b0;
   bit          ser_real = 1'b0;
   int          ser_remain = 0;
   logic [23:0] ser_word = '0;
   int          src_wait = 0;
   logic [23:0] exp_word;

   ws2812_frame_sequencer #(
      .NUM_LEDS     (NUM_LEDS),
      .IDX_W        (IDX_W),
      .LATCH_CYCLES (LATCH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .tick       (tick),
      .pix_req    (pix_req),
      .pix_idx    (pix_idx),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input bit t, input bit e);
      @(negedge clk);
      tick   = t;
      enable = e;
      @(negedge clk);
      tick   = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      for (int i = 0; i < budget && in_frame; i++)
         @(negedge clk);
      if (in_frame)
         checkOutput("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic waitTxStart(input int budget);
      for (int i = 0; i < budget && !tx_start; i++)
         @(negedge clk);
      if (!tx_start)
         checkOutput("txstart_timeout", 64'd1, 64'd0);
   endtask

   // Reference model, pixel source and serializer in one process so the
   // ordering between them is fixed: sample at the edge, check 1 ns later,
   // then drive the inputs for the next edge.
   always @(posedge clk) begin
      s_tick = tick;
      s_en   = enable;
      s_rst  = reset;
      #1;
      cyc++;
      done_now = 1'b0;
      started  = 1'b0;
      if (!s_rst) begin
         in_frame   = 1'b0;
         exp_ovr    = 1'b0;
         exp_frames = '0;
         end_known  = 1'b0;
         exp_pix    = 0;
         falls      = 0;
         checkOutput("reset_outs",
                     {pix_req, pix_idx, tx_start, tx_data, busy, frame_done, overrun, frame_cnt},
                     64'd0);
         pix_valid   = 1'($urandom);
         pix_data    = 24'($urandom);
         tx_busy     = 1'($urandom);
         ser_pending = 1'b0;
         ser_real    = 1'b0;
         ser_remain  = 0;
         src_wait    = 0;
      end else begin
         if (preload_flag && !preload_done) begin
            exp_frames   = 16'hFFFF;
            preload_done = 1'b1;
         end
         if (s_tick && in_frame)
            exp_ovr = 1'b1;
         if (in_frame && end_known && cyc == exp_end) begin
            in_frame   = 1'b0;
            end_known  = 1'b0;
            exp_frames = exp_frames + 16'd1;
            done_now   = 1'b1;
         end else if (!in_frame && s_tick && s_en) begin
            in_frame = 1'b1;
            started  = 1'b1;
            exp_pix  = 0;
            falls    = 0;
         end

         checkOutput("busy", busy, in_frame);
         checkOutput("frame_done", frame_done, done_now);
         checkOutput("frame_cnt", frame_cnt, exp_frames);
         checkOutput("overrun", overrun, exp_ovr);
         if (started)
            checkOutput("start_req", {pix_req, pix_idx}, {1'b1, 8'd0});
         if (!in_frame)
            checkOutput("idle_req", {pix_req, tx_start}, 64'd0);
         if (pix_req)
            checkOutput("pix_idx", pix_idx, exp_pix);
         if (tx_start) begin
            exp_word = (exp_pix < NUM_LEDS) ? mem[exp_pix] : 24'hBAD0BA;
            checkOutput("tx_data", tx_data, exp_word);
            exp_pix++;
         end
         if (tx_busy && ser_real)
            checkOutput("tx_stable", tx_data, ser_word);
         if (done_now)
            checkOutput("tx_count", exp_pix, NUM_LEDS);

         // Pixel source: answers a request after src_delay cycles
         if (pix_valid) begin
            pix_valid = 1'b0;
            pix_data  = 24'($urandom);
            src_wait  = 0;
         end else if (pix_req) begin
            if (src_wait >= src_delay) begin
               pix_valid = 1'b1;
               pix_data  = mem[pix_idx[1:0]];
               src_wait  = 0;
            end else begin
               src_wait++;
               pix_data = 24'($urandom);
            end
         end else begin
            src_wait = 0;
            pix_data = 24'($urandom);
         end

         // Serializer: busy rises the cycle after tx_start, lasts busy_len
         if (ser_pending) begin
            tx_busy     = 1'b1;
            ser_remain  = busy_len;
            ser_pending = 1'b0;
            ser_real    = 1'b1;
         end else if (tx_busy) begin
            ser_remain--;
            if (ser_remain <= 0) begin
               tx_busy = 1'b0;
               if (ser_real && in_frame) begin
                  falls++;
                  if (falls == NUM_LEDS) begin
                     exp_end   = cyc + 1 + LATCH;
                     end_known = 1'b1;
                  end
               end
               ser_real = 1'b0;
            end
         end
         if (tx_start) begin
            ser_pending = 1'b1;
            ser_word    = tx_data;
         end
      end
   end

   initial begin
      reset     = 1'b0;
      tick      = 1'b0;
      enable    = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      tx_busy   = 1'b0;
      mem[0] = 24'h00FF00;
      mem[1] = 24'hFF0000;
      mem[2] = 24'h0000FF;
      mem[3] = 24'hFFFFFF;

      // Reset held for 5 clocks with random inputs
      repeat (5) begin
         @(negedge clk);
         tick   = 1'($urandom);
         enable = 1'($urandom);
      end
      @(negedge clk);
      reset  = 1'b1;
      tick   = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      // Full frame with the fixed pixel set and a 1-cycle serializer
      applyStimulus(1'b1, 1'b1);
      waitIdle(500);
      checkOutput("frame1_cnt", frame_cnt, 16'd1);

      // Slow source and long serializer busy
      src_delay = 7;
      busy_len  = 50;
      applyStimulus(1'b1, 1'b1);
      waitIdle(2000);

      // Tick with enable low starts nothing
      src_delay = 1;
      busy_len  = 3;
      applyStimulus(1'b1, 1'b0);
      repeat (10) @(negedge clk);
      checkOutput("gated_busy", {busy, overrun}, 64'd0);

      // Enable dropped mid-frame, frame still completes
      applyStimulus(1'b1, 1'b1);
      repeat (8) @(negedge clk);
      enable = 1'b0;
      waitIdle(1000);
      checkOutput("drop_en_cnt", frame_cnt, 16'd3);
      enable = 1'b1;

      // Reset during WAIT_TX, next frame restarts at pixel 0
      applyStimulus(1'b1, 1'b1);
      waitTxStart(200);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      waitIdle(1000);
      checkOutput("post_reset_cnt", frame_cnt, 16'd1);

      // Overrun: tick during SEND and on the final LATCH cycle
      src_delay = 0;
      busy_len  = 2;
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 100 && !(pix_req && pix_valid); i++)
         @(negedge clk);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int i = 0; i < 500 && !(end_known && cyc == exp_end - 1); i++)
         @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("ovr_flag", overrun, 1'b1);
      checkOutput("ovr_cnt", frame_cnt, 16'd2);

      // Reset clears the sticky overrun
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Frame counter wrap from a preloaded 0xFFFF
      preload_flag = 1'b1;
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      waitIdle(500);
      checkOutput("wrap_cnt", frame_cnt, 16'h0000);

      // Randomized frames with occasional stray ticks
      for (int f = 0; f < 8; f++) begin
         for (int p = 0; p < NUM_LEDS; p++)
            mem[p] = 24'($urandom);
         src_delay = $urandom_range(0, 4);
         busy_len  = $urandom_range(1, 6);
         applyStimulus(1'b1, 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
         end
         waitIdle(2000);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
